// File: rtl/aes_keyexp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : aes_keyexp_pkg                                               |
// | Purpose : Shared types, round constants and the lane-wise prefix-XOR   |
// |           helper used by the AES-256 key-expansion engine.             |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package aes_keyexp_pkg;

  typedef logic [127:0] key_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Entry 7 is never reached (at most 7 steps); it keeps the array
  // indexable by the full 3-bit step counter.
  localparam logic [7:0] RCON [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

  // Lane j of the result is lane0 ^ ... ^ lanej of k.
  function automatic key_word_t slx(input key_word_t k);
    key_word_t r;
    r[31:0] = k[31:0];
    for (int j = 1; j < 4; j++) begin
      r[32*j +: 32] = r[32*(j-1) +: 32] ^ k[32*j +: 32];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_keyexp_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : aes_keyexp_step                                              |
// | Purpose : One AES-256 schedule step: k[2p+2] from (k[2p], k[2p+1]) and |
// |           k[2p+3] from (k[2p+1], k[2p+2]). Combinational.              |
// | Ports   : k_even, k_odd      keys 2p and 2p+1                          |
// |           k_new_lane3        lane3 of registered k[2p+2] (share mode)  |
// |           half_b             share mode: S-box fed for second half     |
// |           rcon               round constant for this step              |
// |           next_even/next_odd candidate k[2p+2] / k[2p+3]               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module aes_keyexp_step
  import aes_keyexp_pkg::*;
#(
  parameter int SBOX_SHARE = 0
) (
  input  logic [127:0] k_even,
  input  logic [127:0] k_odd,
  input  logic [31:0]  k_new_lane3,
  input  logic         half_b,
  input  logic [7:0]   rcon,
  output logic [127:0] next_even,
  output logic [127:0] next_odd
);

  logic [31:0] w_rot;
  logic [31:0] w_t1;
  logic [31:0] w_t2;

  // RotWord in register byte order: byte 0 moves to the top byte.
  assign w_rot     = {k_odd[103:96], k_odd[127:104]};
  assign next_even = slx(k_even) ^ {4{w_t1}};
  assign next_odd  = slx(k_odd)  ^ {4{w_t2}};

  generate
    if (SBOX_SHARE == 0) begin : g_dual
      logic [31:0] w_sub1;
      logic [31:0] w_sub2;
      logic        w_unused;

      // Both halves are chained in one cycle, so the registered k[2p+2]
      // and the half select are not needed here.
      assign w_unused = ^{k_new_lane3, half_b};

      for (genvar b = 0; b < 4; b++) begin : g_byte
        aes_sbox u_sbox_t1 (.sbox_in(w_rot[8*b +: 8]),            .sbox_out(w_sub1[8*b +: 8]));
        aes_sbox u_sbox_t2 (.sbox_in(next_even[96 + 8*b +: 8]),   .sbox_out(w_sub2[8*b +: 8]));
      end

      assign w_t1 = w_sub1 ^ {24'h0, rcon};
      assign w_t2 = w_sub2;
    end else begin : g_shared
      logic [31:0] w_sbox_word_in;
      logic [31:0] w_sbox_word_out;

      // Only the half being written this cycle gets a meaningful result.
      assign w_sbox_word_in = half_b ? k_new_lane3 : w_rot;

      for (genvar b = 0; b < 4; b++) begin : g_byte
        aes_sbox u_sbox (.sbox_in(w_sbox_word_in[8*b +: 8]), .sbox_out(w_sbox_word_out[8*b +: 8]));
      end

      assign w_t1 = w_sbox_word_out ^ {24'h0, rcon};
      assign w_t2 = w_sbox_word_out;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : aes_sbox                                                     |
// | Purpose : AES forward S-box, one byte, purely combinational.           |
// | Ports   : sbox_in [7:0] -> sbox_out [7:0]                              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] c_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbox_out = c_TABLE[11'd2047 - {sbox_in, 3'b000} -: 8];

endmodule
`default_nettype wire

// File: rtl/aes256_keyexp_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : aes256_keyexp_engine                                         |
// | Purpose : Handshaked AES-256 key expansion producing NUM_KEYS 128-bit  |
// |           round keys from a 256-bit seed, all held in registers.       |
// | Ports   : clk, rstn (sync, active-low)                                 |
// |           start/seed         request, seed sampled on accepting edge   |
// |           busy/done          status; done held until next start        |
// |           keys_flat          key i at [128i+127:128i]                  |
// |           key_rd_idx/data    indexed read, 0 beyond NUM_KEYS           |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module aes256_keyexp_engine
  import aes_keyexp_pkg::*;
#(
  parameter int NUM_KEYS   = 10,
  parameter int SBOX_SHARE = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [255:0]            seed,
  output logic                    busy,
  output logic                    done,
  output logic [128*NUM_KEYS-1:0] keys_flat,
  input  logic [3:0]              key_rd_idx,
  output logic [127:0]            key_rd_data
);

  localparam int c_NUM_STEPS = (NUM_KEYS - 1) / 2;
  localparam int c_LAST_STEP = (c_NUM_STEPS > 0) ? c_NUM_STEPS - 1 : 0;
  localparam bit c_ODD_KEYS  = (NUM_KEYS % 2) == 1;

  key_word_t    r_keys [0:NUM_KEYS-1];
  state_t       r_state;
  logic [2:0]   r_step;
  logic         r_busy;
  logic         r_done;

  key_word_t    w_key_pad [0:15];
  logic [3:0]   w_idx_even;
  logic [3:0]   w_idx_odd;
  logic         w_wr_even;
  logic         w_wr_odd;
  logic         w_last;
  logic [127:0] w_next_even;
  logic [127:0] w_next_odd;

  // Fixed 16-entry view so step and read indices never leave the array.
  generate
    for (genvar i = 0; i < 16; i++) begin : g_pad
      if (i < NUM_KEYS) begin : g_live
        assign w_key_pad[i] = r_keys[i];
      end else begin : g_zero
        assign w_key_pad[i] = '0;
      end
    end
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_flat
      assign keys_flat[128*i +: 128] = r_keys[i];
    end
  endgenerate

  assign w_idx_even = {r_step, 1'b0} + 4'd2;
  assign w_idx_odd  = {r_step, 1'b1} + 4'd2;
  assign w_last     = (r_step == 3'(c_LAST_STEP));
  assign w_wr_even  = (r_state == RUN_A);
  assign w_wr_odd   = (SBOX_SHARE == 0) ? (r_state == RUN_A) : (r_state == RUN_B);

  aes_keyexp_step #(
    .SBOX_SHARE (SBOX_SHARE)
  ) u_step (
    .k_even      (w_key_pad[{r_step, 1'b0}]),
    .k_odd       (w_key_pad[{r_step, 1'b1}]),
    .k_new_lane3 (w_key_pad[w_idx_even][127:96]),
    .half_b      (r_state == RUN_B),
    .rcon        (RCON[r_step]),
    .next_even   (w_next_even),
    .next_odd    (w_next_odd)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_keys[i] <= '0;
      end
      r_state <= IDLE;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // The odd write index runs past the array on an odd final step;
      // the loop bound turns that into a no-op.
      for (int i = 2; i < NUM_KEYS; i++) begin
        if (w_wr_even && (4'(i) == w_idx_even)) r_keys[i] <= w_next_even;
        if (w_wr_odd  && (4'(i) == w_idx_odd))  r_keys[i] <= w_next_odd;
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_keys[0] <= seed[127:0];
            r_keys[1] <= seed[255:128];
            r_step    <= '0;
            if (c_NUM_STEPS == 0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN_A;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        RUN_A: begin
          if ((SBOX_SHARE == 0) || (w_last && c_ODD_KEYS)) begin
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_step <= r_step + 3'd1;
            end
          end else begin
            r_state <= RUN_B;
          end
        end
        RUN_B: begin
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_step  <= r_step + 3'd1;
            r_state <= RUN_A;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign key_rd_data = w_key_pad[key_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_aes256_keyexp_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_aes256_keyexp_engine                                      |
// | Purpose : Directed self-checking bench; four engines (10/9 keys, both  |
// |           S-box modes) driven by shared start/seed/read-index.         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_aes256_keyexp_engine;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic [255:0]   seed;
  logic [3:0]     key_rd_idx;
  logic [3:0]     busy_v;
  logic [3:0]     done_v;
  logic [127:0]   rd_v [4];
  logic [1279:0]  kf_a, kf_b;
  logic [1151:0]  kf_c, kf_d;

  int n_checks = 0;
  int n_pass   = 0;
  int lat [4];
  int n;

  logic [7:0] sref [256];

  // FIPS-197 A.3 expanded words w0..w39 in FIPS byte order.
  localparam logic [31:0] FW [40] = '{
    32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
    32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4,
    32'h9ba35411, 32'h8e6925af, 32'ha51a8b5f, 32'h2067fcde,
    32'ha8b09c1a, 32'h93d194cd, 32'hbe49846e, 32'hb75d5b9a,
    32'hd59aecb8, 32'h5bf3c917, 32'hfee94248, 32'hde8ebe96,
    32'hb5a9328a, 32'h2678a647, 32'h98312229, 32'h2f6c79b3,
    32'h812c81ad, 32'hdadf48ba, 32'h24360af2, 32'hfab8b464,
    32'h98c5bfc9, 32'hbebd198e, 32'h268c3ba7, 32'h09e04214,
    32'h68007bac, 32'hb2df3316, 32'h96e939e4, 32'h6c518d80,
    32'hc814e204, 32'h76a9fb8a, 32'h5025c02d, 32'h59c58239
  };

  localparam logic [255:0] SEED2 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] SEED3 = 256'hdeadbeef0123456789abcdeffedcba9876543210c0ffee00a5a55a5a13579bdf;

  always #5 clk = ~clk;

  aes256_keyexp_engine #(.NUM_KEYS(10), .SBOX_SHARE(0)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start), .seed(seed), .busy(busy_v[0]), .done(done_v[0]),
    .keys_flat(kf_a), .key_rd_idx(key_rd_idx), .key_rd_data(rd_v[0]));
  aes256_keyexp_engine #(.NUM_KEYS(10), .SBOX_SHARE(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start), .seed(seed), .busy(busy_v[1]), .done(done_v[1]),
    .keys_flat(kf_b), .key_rd_idx(key_rd_idx), .key_rd_data(rd_v[1]));
  aes256_keyexp_engine #(.NUM_KEYS(9), .SBOX_SHARE(0)) u_dut_c (
    .clk(clk), .rstn(rstn), .start(start), .seed(seed), .busy(busy_v[2]), .done(done_v[2]),
    .keys_flat(kf_c), .key_rd_idx(key_rd_idx), .key_rd_data(rd_v[2]));
  aes256_keyexp_engine #(.NUM_KEYS(9), .SBOX_SHARE(1)) u_dut_d (
    .clk(clk), .rstn(rstn), .start(start), .seed(seed), .busy(busy_v[3]), .done(done_v[3]),
    .keys_flat(kf_d), .key_rd_idx(key_rd_idx), .key_rd_data(rd_v[3]));

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic int nk(input int w);
    return (w < 2) ? 10 : 9;
  endfunction

  // Reference S-box from first principles: GF(2^8) inverse then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
    return (b << s) | (b >> (8 - s));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sref[t[31:24]], sref[t[23:16]], sref[t[15:8]], sref[t[7:0]]};
  endfunction

  // Textbook FIPS-197 word recurrence, converted to register lane layout.
  function automatic logic [127:0] model_key(input logic [255:0] s, input int k);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = bswap(s[32*i +: 32]);
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {(8'h01 << (i/8 - 1)), 24'h0};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {bswap(w[4*k+3]), bswap(w[4*k+2]), bswap(w[4*k+1]), bswap(w[4*k])};
  endfunction

  function automatic logic [127:0] fips_key(input int k);
    return {bswap(FW[4*k+3]), bswap(FW[4*k+2]), bswap(FW[4*k+1]), bswap(FW[4*k])};
  endfunction

  function automatic logic [255:0] fips_seed();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = bswap(FW[i]);
    return s;
  endfunction

  function automatic logic [127:0] dut_key(input int w, input int i);
    case (w)
      0:       return kf_a[128*i +: 128];
      1:       return kf_b[128*i +: 128];
      2:       return kf_c[128*i +: 128];
      default: return kf_d[128*i +: 128];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_fips(input string tag);
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < nk(w); i++)
        chk($sformatf("%s_u%0d_k%0d", tag, w, i), dut_key(w, i), fips_key(i));
  endtask

  task automatic wait_all(input string tag);
    n = 0;
    while (done_v != 4'hf && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done_timeout"}, 128'(done_v), 128'hf);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) sref[a] = sbox_ref(8'(a));
    rstn = 1'b0; start = 1'b0; seed = '0; key_rd_idx = 4'd0;
    repeat (3) tick();

    // Reset state
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("rst_busy_u%0d", w), 128'(busy_v[w]), 128'h0);
      chk($sformatf("rst_done_u%0d", w), 128'(done_v[w]), 128'h0);
      chk($sformatf("rst_rd_u%0d", w), rd_v[w], 128'h0);
      for (int i = 0; i < nk(w); i++)
        chk($sformatf("rst_u%0d_k%0d", w, i), dut_key(w, i), 128'h0);
    end
    rstn = 1'b1;
    tick();

    // FIPS-197 A.3 run; a start pulse with a different seed while busy
    seed = fips_seed(); start = 1'b1;
    tick();
    start = 1'b0; seed = SEED3;
    chk("busy_after_accept", 128'(busy_v), 128'hf);
    for (int w = 0; w < 4; w++) lat[w] = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 2);
      tick();
      for (int w = 0; w < 4; w++)
        if (lat[w] == 0 && done_v[w]) lat[w] = c;
    end
    start = 1'b0;
    chk("lat_n10_s0", 128'(lat[0]), 128'd4);
    chk("lat_n10_s1", 128'(lat[1]), 128'd8);
    chk("lat_n9_s0",  128'(lat[2]), 128'd4);
    chk("lat_n9_s1",  128'(lat[3]), 128'd7);
    chk("k2_lane0", 128'(kf_a[128*2 +: 32]), 128'h1154a39b);
    chk("k3_lane0", 128'(kf_a[128*3 +: 32]), 128'h1a9cb0a8);
    chk_fips("fips");
    chk("done_held", 128'(done_v), 128'hf);
    chk("busy_clear", 128'(busy_v), 128'h0);

    // Indexed read sweep
    for (int idx = 0; idx < 16; idx++) begin
      key_rd_idx = 4'(idx);
      tick();
      for (int w = 0; w < 4; w++)
        chk($sformatf("rd_u%0d_i%0d", w, idx), rd_v[w], (idx < nk(w)) ? fips_key(idx) : 128'h0);
    end

    // Back-to-back: start in the cycle done rises on the 4-cycle engines
    seed = SEED2; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done_v[0] && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_first_lat", 128'(n), 128'd4);
    seed = SEED3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_done_fall_a", 128'(done_v[0]), 128'h0);
    chk("b2b_busy_a", 128'(busy_v[0]), 128'h1);
    chk("b2b_done_fall_c", 128'(done_v[2]), 128'h0);
    chk("b2b_busy_b", 128'(busy_v[1]), 128'h1);
    wait_all("b2b");
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < nk(w); i++)
        chk($sformatf("b2b_u%0d_k%0d", w, i), dut_key(w, i),
            model_key((w == 0 || w == 2) ? SEED3 : SEED2, i));

    // Reset in cycle 2 of a run
    key_rd_idx = 4'd2;
    seed = SEED2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("abort_busy_u%0d", w), 128'(busy_v[w]), 128'h0);
      chk($sformatf("abort_done_u%0d", w), 128'(done_v[w]), 128'h0);
      chk($sformatf("abort_rd_u%0d", w), rd_v[w], 128'h0);
      for (int i = 0; i < nk(w); i++)
        chk($sformatf("abort_u%0d_k%0d", w, i), dut_key(w, i), 128'h0);
    end
    rstn = 1'b1; seed = fips_seed(); start = 1'b1;
    tick();
    start = 1'b0;
    wait_all("fresh");
    chk_fips("fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes256_keyexp_engine.md
# aes256_keyexp_engine

Parametrised, handshaked AES‑256 key‑expansion engine for the hashing core. It produces `NUM_KEYS` 128‑bit round keys from a 256‑bit seed: key 0 and key 1 are the seed halves, and each later pair comes from the standard AES‑256 schedule. The engine is restartable, uses a start/done handshake, and holds all keys in registers. A selectable S‑box sharing mode trades latency for area. It feeds the round‑key inputs of the AES round pipelines; keys are read either as a flat bus or through an indexed read port.

## Interface
- `NUM_KEYS`, 10: number of round keys generated; legal range 2..15.
- `SBOX_SHARE`, 0: S‑box mode.
  - 0: two S‑box words per step; one key pair per cycle.
  - 1: one S‑box word time‑shared; two cycles per key pair.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset; synchronous, active‑low.
- `start`, in, 1: request expansion; sampled only when not busy.
- `seed`, in, 256: seed[127:0] becomes key 0; seed[255:128] becomes key 1.
- `busy`, out, 1: expansion in progress.
- `done`, out, 1: all keys valid; held until the next accepted start or reset.
- `keys_flat`, out, 128*NUM_KEYS: key i at bits [128i+127:128i].
- `key_rd_idx`, in, 4: read index.
- `key_rd_data`, out, 128: key[key_rd_idx], combinational; reads 0 if idx ≥ NUM_KEYS.

## Operation
- Data layout:
  - Lane j of a key is bits [32j+31:32j]; lane 0 is the first FIPS‑197 word.
  - Byte 0 of each word is bits [7:0] (x86 register layout).
- `slx(k)` is the lane‑wise prefix XOR: lane j = k.lane0 ^ … ^ k.lanej.
- Step p (p = 0..P‑1, where P = ceil((NUM_KEYS‑2)/2)):
  - t1 = SubWord(RotWord(k[2p+1].lane3)) ^ rcon[p], where RotWord(w) = {w[7:0], w[31:8]} and rcon is XORed into bits [7:0].
  - k[2p+2] = slx(k[2p]) ^ {4{t1}}.
  - t2 = SubWord(k[2p+2].lane3), with no rotate and no rcon.
  - k[2p+3] = slx(k[2p+1]) ^ {4{t2}}.
- rcon[p] = 8'h01 << p, giving 01, 02, 04, 08, 10, 20, 40.
- If NUM_KEYS is odd, the last step writes only k[2p+2].
- FSM states: IDLE, RUN_A, RUN_B (only when SBOX_SHARE=1), DONE.
  - IDLE or DONE, with start=1: capture the seed into k0/k1, clear done, set busy, clear the step counter, go to RUN_A. If NUM_KEYS=2, go straight to DONE.
  - RUN_A, SBOX_SHARE=0: write k[2p+2] and k[2p+3] in the same cycle.
  - RUN_A, SBOX_SHARE=1: write k[2p+2] and go to RUN_B. On the final odd half‑step, skip RUN_B.
  - RUN_B: write k[2p+3]. The S‑box input is muxed between the two sources.
  - Last step complete: go to DONE with busy=0 and done=1.
- start while busy is ignored: no restart and no error.
- Keys not yet written in the current run keep their stale values; consumers use them only once done=1.
- The seed is sampled only on the accepting edge; later seed changes have no effect.

## Timing
- Reset values: busy=0, done=0, every key register 0, FSM in IDLE, step counter 0. Consequently keys_flat=0 and key_rd_data=0.
- Reset mid‑run aborts immediately; the first edge with rstn=1 behaves as IDLE.
- Accepting edge is T:
  - busy=1 after T.
  - With SBOX_SHARE=0, step p is written at edge T+1+p.
  - done=1 and busy=0 become visible after edge T+P.
- Start‑to‑done latency:
  - SBOX_SHARE=0: P cycles. NUM_KEYS=10 gives 4.
  - SBOX_SHARE=1: 2P cycles, or 2P‑1 when NUM_KEYS is odd. NUM_KEYS=10 gives 8.
- start may be asserted in the cycle done is high. It is accepted, and done falls after that edge; this gives back‑to‑back runs with no idle cycle.
- rstn has priority over start.

## Structure
- Package `aes_keyexp_pkg`:
  - RCON constant array.
  - State enum.
  - `slx` prefix‑XOR function.
  - Key‑word typedef (128‑bit).
- Sub‑module `aes_keyexp_step`, combinational:
  - Reuses the existing `aes_sbox` for SubWord.
  - Computes slx, rotate and rcon.
  - Exposes a one‑word S‑box port for share mode.

## Test plan
- FIPS‑197 A.3 seed, NUM_KEYS=10, SBOX_SHARE=0.
  - Seed is 603deb10…0914dff4, so seed lane0 = 32'h10eb3d60.
  - Required: k2.lane0 = 32'h1154a39b (FIPS word 9ba35411) and k3.lane0 = 32'h1a9cb0a8 (FIPS a8b09c1a).
  - Required: done exactly 4 cycles after the accepting edge.
- Same seed with SBOX_SHARE=1: identical keys_flat; done after 8 cycles.
- NUM_KEYS=9 in both modes: k8 matches the NUM_KEYS=10 result; latencies are 4 and 7 cycles.
- start pulses while busy are ignored; start in the done cycle restarts with a new seed; the second result matches a reference model.
- rstn low during cycle 2 of a run: all outputs 0 on the next cycle; a fresh start completes correctly.
- key_rd_idx swept 0..15: data matches keys_flat for indices below NUM_KEYS; indices at or above NUM_KEYS read 0.
